// File: rtl/s2_pkg.sv
// s2_pkg: shared state type, index-width helper and lane-select macro for the stage-2 path
`define S2_LANE(v, i, w) v[(w)*((i)+1)-1 -: (w)]
package s2_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    function automatic int iw_of(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction
endpackage

// File: rtl/s2_max_cmp.sv
// s2_max_cmp: signed compare-and-select; strict greater-than keeps the lower index on ties
module s2_max_cmp #(
    parameter int n  = 32,
    parameter int IW = 3
) (
    input  logic [n-1:0]  cand,
    input  logic [IW-1:0] cand_idx,
    input  logic [n-1:0]  best,
    input  logic [IW-1:0] best_idx,
    output logic [n-1:0]  new_best,
    output logic [IW-1:0] new_idx
);
    logic gt;
    always_comb begin
        gt       = $signed(cand) > $signed(best);
        new_best = gt ? cand : best;
        new_idx  = gt ? cand_idx : best_idx;
    end
endmodule

// File: rtl/s2_argmax_collector.sv
// s2_argmax_collector: captures final stage-2 outputs and scans them one lane per cycle for the argmax
module s2_argmax_collector
    import s2_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int n  = 32,
    localparam int IW = iw_of(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N*n-1:0] Y,
    input  logic          y_valid,
    input  logic          invalid,
    input  logic          cfflag,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] class_idx,
    output logic [n-1:0]  max_val,
    output logic          err,
    output logic          overrun
);
    state_t         state_q, state_d;
    logic [N*n-1:0] lane_buf;
    logic [n-1:0]   best_val, cmp_val;
    logic [IW-1:0]  best_idx, cmp_idx, idx_q;
    logic           err_l, start;

    assign start = (state_q == IDLE) && y_valid && !cfflag;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = (state_q == IDLE) ? (start ? ((N == 1) ? DONE : SCAN) : IDLE)
                : (state_q == SCAN) ? ((idx_q == IW'(N - 1)) ? DONE : SCAN)
                : IDLE;
    end

    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
    end

    s2_max_cmp #(.n(n), .IW(IW)) u_cmp (
        .cand     (`S2_LANE(lane_buf, idx_q, n)),
        .cand_idx (idx_q),
        .best     (best_val),
        .best_idx (best_idx),
        .new_best (cmp_val),
        .new_idx  (cmp_idx)
    );

    // The scan works from the buffered copy, so Y may change or freeze once captured.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            lane_buf  <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            idx_q     <= '0;
            err_l     <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
            err       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (busy && y_valid) overrun <= 1'b1;
            if (start) begin
                lane_buf <= Y;
                best_val <= `S2_LANE(Y, 0, n);
                best_idx <= '0;
                idx_q    <= IW'(1);
                err_l    <= invalid;
            end else if (state_q == SCAN) begin
                best_val <= cmp_val;
                best_idx <= cmp_idx;
                err_l    <= err_l | invalid;
                idx_q    <= idx_q + IW'(1);
            end else if (state_q == DONE) begin
                class_idx <= best_idx;
                max_val   <= best_val;
                err       <= err_l | invalid;
            end
        end
endmodule

// File: tb/tb_s2_argmax_collector.sv
// tb_s2_argmax_collector: directed scenarios for the stage-2 argmax collector
module tb_s2_argmax_collector;
    localparam int NL = 8;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NL*W-1:0] Y = '0;
    logic            y_valid = 1'b0, invalid = 1'b0, cfflag = 1'b0;
    logic            busy, done, err, overrun;
    logic [2:0]      class_idx;
    logic [W-1:0]    max_val;
    int              n_cmp = 0, n_bad = 0;

    s2_argmax_collector #(.N(NL), .n(W)) dut (
        .clk(clk), .reset(reset), .Y(Y), .y_valid(y_valid), .invalid(invalid),
        .cfflag(cfflag), .busy(busy), .done(done), .class_idx(class_idx),
        .max_val(max_val), .err(err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [NL*W-1:0] pk(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [NL*W-1:0] y);
        Y = y;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({busy, done, err, overrun} !== 4'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, overrun});
        end
        n_cmp++;
        if ({class_idx, max_val} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got idx=%0d val=%h want 0/0", class_idx, max_val);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_tie();
        int lat;
        start(pk(3, -5, 7, 2, 7, 0, -1, 6));
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL tie_busy: got busy=%b done=%b want 1/0", busy, done);
        end
        wait_done(lat);
        n_cmp++;
        if (lat !== NL - 1) begin
            n_bad++; $display("FAIL tie_latency: got %0d want %0d", lat, NL - 1);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL tie_pulse: got done=%b busy=%b want 0/0", done, busy);
        end
        n_cmp++;
        if (class_idx !== 3'd2 || max_val !== 32'd7 || err !== 1'b0) begin
            n_bad++; $display("FAIL tie_result: got idx=%0d val=%h err=%b want 2/7/0", class_idx, max_val, err);
        end
        Y = pk(100, 100, 100, 100, 100, 100, 100, 100);
        repeat (3) tick();
        n_cmp++;
        if (class_idx !== 3'd2 || max_val !== 32'd7) begin
            n_bad++; $display("FAIL tie_hold: got idx=%0d val=%h want 2/7", class_idx, max_val);
        end
    endtask

    task automatic test_negative();
        int lat;
        start(pk(-9, -2, -8, -100, -3, -2, -50, -7));
        wait_done(lat);
        tick();
        n_cmp++;
        if (lat !== NL - 1 || class_idx !== 3'd1 || max_val !== 32'hFFFF_FFFE) begin
            n_bad++; $display("FAIL negative: got lat=%0d idx=%0d val=%h want 7/1/fffffffe", lat, class_idx, max_val);
        end
    endtask

    task automatic test_extreme();
        int lat;
        start(pk(-1, -1, -1, 32'h8000_0000, -1, -1, 32'h7FFF_FFFF, -1));
        wait_done(lat);
        tick();
        n_cmp++;
        if (class_idx !== 3'd6 || max_val !== 32'h7FFF_FFFF) begin
            n_bad++; $display("FAIL extreme: got idx=%0d val=%h want 6/7fffffff", class_idx, max_val);
        end
    endtask

    task automatic test_invalid();
        int lat;
        start(pk(1, 2, 3, 4, 5, 6, 7, 8));
        repeat (2) tick();
        invalid = 1'b1;
        tick();
        invalid = 1'b0;
        wait_done(lat);
        n_cmp++;
        if (lat + 3 !== NL - 1) begin
            n_bad++; $display("FAIL invalid_latency: got %0d want %0d", lat + 3, NL - 1);
        end
        tick();
        n_cmp++;
        if (err !== 1'b1 || class_idx !== 3'd7 || max_val !== 32'd8) begin
            n_bad++; $display("FAIL invalid_err: got err=%b idx=%0d val=%h want 1/7/8", err, class_idx, max_val);
        end
        start(pk(1, 2, 3, 4, 5, 6, 7, 8));
        wait_done(lat);
        tick();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL invalid_clean: got err=%b want 0", err);
        end
    endtask

    task automatic test_cfflag();
        int seen, lat;
        cfflag = 1'b1;
        start(pk(3, -5, 7, 2, 7, 0, -1, 6));
        seen = 0;
        repeat (10) begin
            if (busy || done) seen++;
            tick();
        end
        cfflag = 1'b0;
        n_cmp++;
        if (seen !== 0 || overrun !== 1'b0) begin
            n_bad++; $display("FAIL cfflag_ignore: got active=%0d overrun=%b want 0/0", seen, overrun);
        end
        n_cmp++;
        if (class_idx !== 3'd7) begin
            n_bad++; $display("FAIL cfflag_hold: got idx=%0d want 7", class_idx);
        end
        start(pk(3, -5, 7, 2, 7, 0, -1, 6));
        wait_done(lat);
        tick();
        n_cmp++;
        if (lat !== NL - 1 || class_idx !== 3'd2 || max_val !== 32'd7) begin
            n_bad++; $display("FAIL cfflag_clear: got lat=%0d idx=%0d val=%h want 7/2/7", lat, class_idx, max_val);
        end
    endtask

    task automatic test_overrun();
        int dones;
        start(pk(10, 20, 30, 40, 50, 60, 70, 5));
        repeat (2) tick();
        start(pk(99, 99, 99, 99, 99, 99, 99, 99));
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++; $display("FAIL overrun_set: got %b want 1", overrun);
        end
        dones = 0;
        repeat (12) begin
            if (done) dones++;
            tick();
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++; $display("FAIL overrun_dones: got %0d want 1", dones);
        end
        n_cmp++;
        if (class_idx !== 3'd6 || max_val !== 32'd70 || overrun !== 1'b1) begin
            n_bad++; $display("FAIL overrun_result: got idx=%0d val=%h ovr=%b want 6/46/1", class_idx, max_val, overrun);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        start(pk(3, -5, 7, 2, 7, 0, -1, 6));
        repeat (3) tick();
        #3 reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, err, overrun} !== 4'b0 || {class_idx, max_val} !== '0) begin
            n_bad++; $display("FAIL async_reset: got busy=%b done=%b err=%b ovr=%b idx=%0d val=%h want all 0",
                              busy, done, err, overrun, class_idx, max_val);
        end
        #1 reset = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL async_idle: got busy=%b want 0", busy);
        end
        start(pk(-9, -2, -8, -100, -3, -2, -50, -7));
        wait_done(lat);
        tick();
        n_cmp++;
        if (lat !== NL - 1 || class_idx !== 3'd1 || max_val !== 32'hFFFF_FFFE || overrun !== 1'b0) begin
            n_bad++; $display("FAIL async_after: got lat=%0d idx=%0d val=%h ovr=%b want 7/1/fffffffe/0",
                              lat, class_idx, max_val, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_negative();
        test_extreme();
        test_invalid();
        test_cfflag();
        test_overrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
